// File: rtl/lsu_mem_port.sv
// Memory-stage load/store unit: turns the EX/MEM register contents into a
// request/grant/response transaction with data memory, stalls the pipeline
// while the access is outstanding, and returns extended load data for writeback.
module lsu_mem_port #(
  parameter int unsigned AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   alu_data_i,
  input  logic [31:0]   st_data_i,
  input  logic [3:0]    ld_op_i,
  input  logic          mem_wren_i,
  input  logic          is_load_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          rd_wren_i,
  output logic          stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_bmask_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic [31:0]   ld_data_o,
  output logic          ld_valid_o,
  output logic [4:0]    rd_addr_o,
  output logic          rd_wren_o,
  output logic          misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [3:0]    bmask_q;
  logic [4:0]    rd_addr_q;
  logic          rd_wren_q;
  logic [31:0]   ld_data_q;

  logic          access;
  logic          misalign;
  logic [1:0]    size_in;
  logic [31:0]   wdata_in;
  logic [3:0]    bmask_in;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_ext;

  // ld_op_i[3] is reserved and deliberately ignored
  logic unused_op;
  assign unused_op = ld_op_i[3];

  // Decode the incoming access: size, alignment, store lane replication
  always_comb begin
    access   = is_load_i | mem_wren_i;
    size_in  = SzWord;
    wdata_in = st_data_i;
    bmask_in = 4'b1111;
    unique case (ld_op_i[1:0])
      2'b00: begin
        size_in  = SzByte;
        wdata_in = {4{st_data_i[7:0]}};
        bmask_in = 4'b0001 << alu_data_i[1:0];
      end
      2'b01: begin
        size_in  = SzHalf;
        wdata_in = {2{st_data_i[15:0]}};
        bmask_in = alu_data_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        size_in  = SzWord;
        wdata_in = st_data_i;
        bmask_in = 4'b1111;
      end
    endcase
    misalign = ((size_in == SzHalf) && alu_data_i[0]) ||
               ((size_in == SzWord) && (alu_data_i[1:0] != 2'b00));
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    byte_sel = mem_rdata_i[7:0];
    unique case (addr_q[1:0])
      2'b00: byte_sel = mem_rdata_i[7:0];
      2'b01: byte_sel = mem_rdata_i[15:8];
      2'b10: byte_sel = mem_rdata_i[23:16];
      2'b11: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (size_q)
      SzByte:  ld_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
      SzHalf:  ld_ext = {{16{sign_q & half_sel[15]}}, half_sel};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  // Transaction FSM; request fields are latched in IDLE and held until DONE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= SzByte;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      rd_addr_q <= '0;
      rd_wren_q <= 1'b0;
      ld_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access && !misalign) begin
            addr_q    <= alu_data_i[AW-1:0];
            size_q    <= size_in;
            sign_q    <= ~ld_op_i[2];
            we_q      <= mem_wren_i;
            wdata_q   <= wdata_in;
            bmask_q   <= bmask_in;
            rd_addr_q <= rd_addr_i;
            rd_wren_q <= rd_wren_i;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (mem_gnt_i) begin
            if (we_q) begin
              state_q <= StDone;
            end else if (mem_rvalid_i) begin
              ld_data_q <= ld_ext;
              state_q   <= StDone;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            ld_data_q <= ld_ext;
            state_q   <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs; all forced low while reset is asserted
  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_bmask_o = '0;
    ld_valid_o  = 1'b0;
    rd_addr_o   = '0;
    rd_wren_o   = 1'b0;
    misalign_o  = 1'b0;
    ld_data_o   = ld_data_q;
    if (rst_i) begin
      unique case (state_q)
        StIdle: begin
          if (!access) begin
            // non-memory instruction: pass the ALU-result writeback through
            rd_addr_o = rd_addr_i;
            rd_wren_o = rd_wren_i;
          end else if (misalign) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
          end
        end
        StReq: begin
          stall_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = we_q;
          mem_addr_o  = {addr_q[AW-1:2], 2'b00};
          mem_wdata_o = wdata_q;
          mem_bmask_o = bmask_q;
        end
        StWait: stall_o = 1'b1;
        StDone: begin
          if (!we_q) begin
            ld_valid_o = 1'b1;
            rd_addr_o  = rd_addr_q;
            rd_wren_o  = rd_wren_q;
          end
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-stage load/store unit on the consumer side of the EX/MEM pipeline register.
- Takes the registered address, store data, load op and control, and runs a variable-latency request/grant/response handshake with the data memory.
- Drives a stall back to the pipeline registers while an access is outstanding.
- Returns aligned, sign/zero-extended load data with its destination register for writeback.

Parameters:
AW, 32, address width; low 2 bits select the byte lane

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
alu_data_i  in  32  effective address from EX/MEM
st_data_i  in  32  store data from EX/MEM
ld_op_i  in  4  [2:0] = funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU); [3] reserved, ignored
mem_wren_i  in  1  store request
is_load_i  in  1  load request
rd_addr_i  in  5  destination register
rd_wren_i  in  1  destination write enable
stall_o  out  1  hold EX/MEM and upstream registers (drives their enable low)
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1 = write
mem_addr_o  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
mem_wdata_o  out  32  lane-replicated store data
mem_bmask_o  out  4  byte enables
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data word
ld_data_o  out  32  extended load result
ld_valid_o  out  1  one-cycle pulse, load result valid
rd_addr_o  out  5  destination for writeback
rd_wren_o  out  1  writeback enable (qualified)
misalign_o  out  1  one-cycle pulse, misaligned access dropped

Behaviour:
- Reset (async, rst_i=0): state IDLE; every output 0, including mem_* outputs, ld_data_o, rd_addr_o, rd_wren_o and misalign_o.
- A reset asserted mid-transaction abandons the access: mem_req_o drops immediately and no late rvalid is consumed.
- Access present = is_load_i | mem_wren_i. If both are set, the store wins and is_load_i is ignored.
- Misaligned access:
  - Definition: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - In IDLE: no request issued, misalign_o pulses for 1 cycle, stall_o=0, rd_wren_o=0.
- IDLE:
  - No access: stall_o=0 and rd_addr_o/rd_wren_o follow the inputs combinationally (ALU-result passthrough).
  - Aligned access: stall_o=1 combinationally. Latch addr, size, sign, we, wdata, bmask, rd_addr and rd_wren. Go to REQ.
- REQ:
  - mem_req_o=1; mem_* outputs are stable from the latched values. stall_o=1.
  - mem_gnt_i=0: stay in REQ and hold every request field.
  - mem_gnt_i=1, store: go to DONE.
  - mem_gnt_i=1, load, same-cycle mem_rvalid_i: capture data and go to DONE.
  - mem_gnt_i=1, load, no rvalid: go to WAIT.
  - mem_req_o drops in the cycle after the grant.
- WAIT: mem_req_o=0, stall_o=1. mem_rvalid_i=1 captures mem_rdata_i and goes to DONE. rvalid in IDLE, DONE or store transactions is ignored.
- DONE:
  - stall_o=0, so EX/MEM advances on this edge. Next state is IDLE unconditionally; the same instruction never re-triggers.
  - Load: ld_valid_o=1, ld_data_o valid, rd_wren_o = latched rd_wren, rd_addr_o = latched rd_addr.
  - Store: ld_valid_o=0, rd_wren_o=0.
- ld_data_o holds its value until the next captured load.
- Load extraction:
  - B/BU take lane addr[1:0]; H/HU take half addr[1].
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes the word through.
- Store lanes:
  - B: wdata = {4{st[7:0]}}, bmask = 0001 << addr[1:0].
  - H: wdata = {2{st[15:0]}}, bmask = addr[1] ? 1100 : 0011.
  - W: wdata = st, bmask = 1111.
- Latency:
  - Zero-wait memory (gnt and rvalid in the REQ cycle): 3 cycles in the MEM stage (IDLE, REQ, DONE), i.e. 2 stall cycles.
  - Each gnt-wait or rvalid-wait cycle adds one cycle.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, zero-wait -> bmask n/a, mem_addr_o=0x1000; ld_data_o=0xFFFF_FF80, ld_valid_o pulses in cycle 3, stall_o high exactly 2 cycles.
- LHU, addr 0x2002, rdata 0xBEEF_0000, gnt delayed 2 cycles, rvalid 3 cycles after gnt -> mem_req_o held 3 cycles with stable addr; ld_data_o=0x0000_BEEF; rd_addr_o=5'd7 and rd_wren_o=1 only in DONE.
- SB, st_data 0x1234_56AB, addr 0x3001 -> mem_we_o=1, mem_wdata_o=0xABAB_ABAB, mem_bmask_o=0010; DONE has rd_wren_o=0 and ld_valid_o=0.
- LW, addr 0x4002 -> misalign_o pulses 1 cycle, mem_req_o never asserts, stall_o=0.
- Back-to-back SW then LW (0x5000, rdata 0xCAFEF00D) -> second access starts in the cycle after DONE; result 0xCAFEF00D; no duplicate request for the SW.
- rst_i low during WAIT, late rvalid arrives -> all outputs 0 immediately; after release, state IDLE and ld_valid_o never pulses.
